program_loader: RTL and testbench



---
 rtl/cpu_pkg.sv | 21 ++
 rtl/loader_fsm.sv | 99 +++++++++
 rtl/program_loader.sv | 163 ++++++++++++++++
 tb/tb_program_loader.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the program loader: FSM state encoding and word packing constant.
package cpu_pkg;

    localparam int BYTES_PER_WORD = 2;

    typedef enum logic [2:0] {
        ST_LEN  = 3'd0,
        ST_HI   = 3'd1,
        ST_LO   = 3'd2,
        ST_WR   = 3'd3,
        ST_CHK  = 3'd4,
        ST_DONE = 3'd5,
        ST_ERR  = 3'd6
    } state_e;

    // States in which the loader takes a byte from the stream
    function automatic logic state_accepts(input state_e s);
        return (s == ST_LEN) || (s == ST_HI) || (s == ST_LO) || (s == ST_CHK);
    endfunction

endpackage

// File: rtl/loader_fsm.sv
// Control FSM of the program loader: state register and registered byte_ready decode.
// The CHK state is entered only when PROGRAM_LOADER_CHECKSUM_EN is defined.
module loader_fsm
    import cpu_pkg::*;
(
    input  logic   clk,
    input  logic   reset,
    input  logic   byte_valid,
    input  logic   len_zero,
    input  logic   len_too_big,
    input  logic   last_word,
    input  logic   chk_ok,
    output state_e state,
    output state_e state_next,
    output logic   byte_ready
);

    state_e state_q;
    state_e state_d;
    logic   byte_ready_q;
    logic   xfer_s;

    assign xfer_s = byte_valid && byte_ready_q;

    // Next-state decode
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_LEN: begin
                if (!xfer_s) begin
                    state_d = ST_LEN;
                end else if (len_too_big) begin
                    state_d = ST_ERR;
                end else if (len_zero) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                    state_d = ST_CHK;
`else
                    state_d = ST_DONE;
`endif
                end else begin
                    state_d = ST_HI;
                end
            end
            ST_HI: begin
                if (xfer_s) begin
                    state_d = ST_LO;
                end else begin
                    state_d = ST_HI;
                end
            end
            ST_LO: begin
                if (xfer_s) begin
                    state_d = ST_WR;
                end else begin
                    state_d = ST_LO;
                end
            end
            ST_WR: begin
                if (last_word) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                    state_d = ST_CHK;
`else
                    state_d = ST_DONE;
`endif
                end else begin
                    state_d = ST_HI;
                end
            end
            ST_CHK: begin
                if (!xfer_s) begin
                    state_d = ST_CHK;
                end else if (chk_ok) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_ERR;
                end
            end
            ST_DONE: state_d = ST_DONE;
            ST_ERR:  state_d = ST_ERR;
            default: state_d = ST_ERR;
        endcase
    end

    // State register; ready is decoded from the next state so it is valid with the state
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= ST_LEN;
            byte_ready_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            byte_ready_q <= state_accepts(state_d);
        end
    end

    assign state      = state_q;
    assign state_next = state_d;
    assign byte_ready = byte_ready_q;

endmodule

// File: rtl/program_loader.sv
// Loads a length-prefixed byte stream into RAM as 16-bit words and holds the CPU in reset until done.
// Define PROGRAM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module program_loader
    import cpu_pkg::*;
#(
    parameter int DATA_WIDTH = 8 * BYTES_PER_WORD,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            byte_in,
    input  logic                  byte_valid,
    output logic                  byte_ready,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_write,
    output logic                  cpu_reset,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_WIDTH:0]   word_count
);

    localparam int unsigned CAPACITY = 2 ** ADDR_WIDTH;

    state_e state_s;
    state_e state_next_s;
    logic   xfer_s;
    logic   len_zero_s;
    logic   len_too_big_s;
    logic   last_word_s;
    logic   chk_ok_s;

    logic [7:0]            len_q, len_d;
    logic [7:0]            hi_q, hi_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  mem_write_q, mem_write_d;
    logic [ADDR_WIDTH:0]   word_count_q, word_count_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;
    logic                  cpu_reset_q, cpu_reset_d;

    loader_fsm u_fsm (
        .clk         (clk),
        .reset       (reset),
        .byte_valid  (byte_valid),
        .len_zero    (len_zero_s),
        .len_too_big (len_too_big_s),
        .last_word   (last_word_s),
        .chk_ok      (chk_ok_s),
        .state       (state_s),
        .state_next  (state_next_s),
        .byte_ready  (byte_ready)
    );

    assign xfer_s        = byte_valid && byte_ready;
    assign len_zero_s    = (byte_in == 8'd0);
    assign len_too_big_s = (32'(byte_in) > CAPACITY);
    assign last_word_s   = ((32'(word_count_q) + 32'd1) == 32'(len_q));

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [7:0] csum_q, csum_d;

    assign chk_ok_s = (byte_in == csum_q);

    // Running XOR over the length byte and every data byte
    always_comb begin
        csum_d = csum_q;
        if (xfer_s && (state_s == ST_LEN)) begin
            csum_d = byte_in;
        end else if (xfer_s && ((state_s == ST_HI) || (state_s == ST_LO))) begin
            csum_d = csum_q ^ byte_in;
        end else begin
            csum_d = csum_q;
        end
    end

    // Checksum register
    always_ff @(posedge clk) begin
        if (!reset) begin
            csum_q <= 8'd0;
        end else begin
            csum_q <= csum_d;
        end
    end
`else
    assign chk_ok_s = 1'b0;
`endif

    // Datapath: length/high-byte latches, word assembly, write strobe and word counter
    always_comb begin
        len_d        = len_q;
        hi_d         = hi_q;
        wdata_d      = wdata_q;
        addr_d       = addr_q;
        mem_write_d  = 1'b0;
        word_count_d = word_count_q;
        case (state_s)
            ST_LEN: begin
                if (xfer_s) begin
                    len_d = byte_in;
                end else begin
                    len_d = len_q;
                end
            end
            ST_HI: begin
                if (xfer_s) begin
                    hi_d = byte_in;
                end else begin
                    hi_d = hi_q;
                end
            end
            ST_LO: begin
                if (xfer_s) begin
                    wdata_d     = {hi_q, byte_in};
                    addr_d      = word_count_q[ADDR_WIDTH-1:0];
                    mem_write_d = 1'b1;
                end else begin
                    mem_write_d = 1'b0;
                end
            end
            ST_WR:   word_count_d = word_count_q + {{ADDR_WIDTH{1'b0}}, 1'b1};
            default: word_count_d = word_count_q;
        endcase
        done_d      = (state_next_s == ST_DONE);
        error_d     = (state_next_s == ST_ERR);
        cpu_reset_d = (state_next_s != ST_DONE);
    end

    // Datapath and status registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            len_q        <= 8'd0;
            hi_q         <= 8'd0;
            wdata_q      <= '0;
            addr_q       <= '0;
            mem_write_q  <= 1'b0;
            word_count_q <= '0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            cpu_reset_q  <= 1'b1;
        end else begin
            len_q        <= len_d;
            hi_q         <= hi_d;
            wdata_q      <= wdata_d;
            addr_q       <= addr_d;
            mem_write_q  <= mem_write_d;
            word_count_q <= word_count_d;
            done_q       <= done_d;
            error_q      <= error_d;
            cpu_reset_q  <= cpu_reset_d;
        end
    end

    assign mem_address = addr_q;
    assign mem_wdata   = wdata_q;
    assign mem_write   = mem_write_q;
    assign word_count  = word_count_q;
    assign done        = done_q;
    assign error       = error_q;
    assign cpu_reset   = cpu_reset_q;

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: table-driven loads with a write scoreboard,
// plus hand sequences for reset mid-load, checksum and a 2-bit-address overflow instance.
module tb_program_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_valid2;

    logic        byte_ready, mem_write, cpu_reset, done, error;
    logic [7:0]  mem_address;
    logic [15:0] mem_wdata;
    logic [8:0]  word_count;

    logic        byte_ready2, mem_write2, cpu_reset2, done2, error2;
    logic [1:0]  mem_address2;
    logic [15:0] mem_wdata2;
    logic [2:0]  word_count2;

    int n_cmp = 0;
    int n_bad = 0;
    logic [23:0] exp_q[$];
    logic prev_mw = 1'b0;
    logic mw2_seen = 1'b0;

    always #5 clk = ~clk;

    program_loader #(.DATA_WIDTH(16), .ADDR_WIDTH(8)) dut (
        .clk(clk), .reset(reset), .byte_in(byte_in), .byte_valid(byte_valid),
        .byte_ready(byte_ready), .mem_address(mem_address), .mem_wdata(mem_wdata),
        .mem_write(mem_write), .cpu_reset(cpu_reset), .done(done), .error(error),
        .word_count(word_count)
    );

    program_loader #(.DATA_WIDTH(16), .ADDR_WIDTH(2)) dut2 (
        .clk(clk), .reset(reset), .byte_in(byte_in), .byte_valid(byte_valid2),
        .byte_ready(byte_ready2), .mem_address(mem_address2), .mem_wdata(mem_wdata2),
        .mem_write(mem_write2), .cpu_reset(cpu_reset2), .done(done2), .error(error2),
        .word_count(word_count2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every write strobe pops one expected {addr, data}
    always @(negedge clk) begin
        logic [23:0] e;
        if (mem_write === 1'b1) begin
            check("ready_low_in_wr", 32'(byte_ready), 32'd0);
            check("single_cycle_write", 32'(prev_mw), 32'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_write", 32'(mem_write), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("write_addr", 32'(mem_address), 32'(e[23:16]));
                check("write_data", 32'(mem_wdata), 32'(e[15:0]));
            end
        end
        prev_mw = mem_write;
        check("cpu_reset_vs_done", 32'(cpu_reset), 32'(!done));
        if (mem_write2 === 1'b1) mw2_seen = 1'b1;
    end

    task automatic do_reset();
        byte_valid  = 1'b0;
        byte_valid2 = 1'b0;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_byte_ready", 32'(byte_ready), 32'd0);
        check("rst_mem_write", 32'(mem_write), 32'd0);
        check("rst_mem_address", 32'(mem_address), 32'd0);
        check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_word_count", 32'(word_count), 32'd0);
        check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
        reset = 1'b1;
    endtask

    // Offer one byte after gap idle cycles; returns at posedge+1 of the transfer
    task automatic send(input logic [7:0] b, input int gap);
        int   cnt;
        logic acc;
        for (int i = 0; i < gap; i++) begin
            @(posedge clk);
            #1;
        end
        byte_in    = b;
        byte_valid = 1'b1;
        cnt = 0;
        acc = 1'b0;
        while (!acc && cnt < 40) begin
            @(negedge clk);
            acc = byte_ready;
            @(posedge clk);
            #1;
            cnt++;
        end
        byte_valid = 1'b0;
        check("send_accepted", 32'(acc), 32'd1);
    endtask

    task automatic wait_end();
        int cnt;
        cnt = 0;
        while (!(done || error) && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        check("finish_within_budget", 32'(done || error), 32'd1);
    endtask

    typedef struct {
        logic [7:0]  len;
        logic [15:0] w[4];
        bit          gaps;
        logic [8:0]  exp_wc;
    } vec_t;

    vec_t vt[4];

    initial begin
        logic [7:0] csum;
        int g;
        byte_in = 8'd0;

        vt[0].len = 8'd2; vt[0].w[0] = 16'hA123; vt[0].w[1] = 16'h4567; vt[0].gaps = 1'b0; vt[0].exp_wc = 9'd2;
        vt[1].len = 8'd0; vt[1].w[0] = 16'h0000; vt[1].w[1] = 16'h0000; vt[1].gaps = 1'b0; vt[1].exp_wc = 9'd0;
        vt[2].len = 8'd3; vt[2].w[0] = 16'hDEAD; vt[2].w[1] = 16'hBEEF; vt[2].w[2] = 16'h0F0F; vt[2].gaps = 1'b0; vt[2].exp_wc = 9'd3;
        vt[3].len = 8'd3; vt[3].w[0] = 16'hDEAD; vt[3].w[1] = 16'hBEEF; vt[3].w[2] = 16'h0F0F; vt[3].gaps = 1'b1; vt[3].exp_wc = 9'd3;

        for (int v = 0; v < 4; v++) begin
            do_reset();
            g = vt[v].gaps ? int'($urandom_range(1, 3)) : 0;
            csum = vt[v].len;
            send(vt[v].len, g);
`ifndef PROGRAM_LOADER_CHECKSUM_EN
            if (vt[v].len == 8'd0) check("len0_done_latency", 32'(done), 32'd1);
`endif
            for (int i = 0; i < int'(vt[v].len); i++) begin
                exp_q.push_back({8'(i), vt[v].w[i]});
                g = vt[v].gaps ? int'($urandom_range(1, 3)) : 0;
                send(vt[v].w[i][15:8], g);
                g = vt[v].gaps ? int'($urandom_range(1, 3)) : 0;
                send(vt[v].w[i][7:0], g);
                csum = csum ^ vt[v].w[i][15:8] ^ vt[v].w[i][7:0];
                check("write_latency", 32'(mem_write), 32'd1);
            end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            send(csum, 0);
`else
            if (vt[v].len != 8'd0) begin
                @(posedge clk);
                #1;
                check("done_latency", 32'(done), 32'd1);
            end
`endif
            wait_end();
            check("end_done", 32'(done), 32'd1);
            check("end_error", 32'(error), 32'd0);
            check("end_word_count", 32'(word_count), 32'(vt[v].exp_wc));
            check("end_cpu_reset", 32'(cpu_reset), 32'd0);
            check("writes_all_seen", 32'(exp_q.size()), 32'd0);
            // DONE ignores further bytes
            byte_in = 8'h55;
            byte_valid = 1'b1;
            repeat (3) @(posedge clk);
            #1;
            check("done_ready_low", 32'(byte_ready), 32'd0);
            check("done_holds", 32'(done), 32'd1);
            check("done_count_holds", 32'(word_count), 32'(vt[v].exp_wc));
            byte_valid = 1'b0;
        end

        // Reset after the first word of a 3-word load, then a fresh 1-word load
        do_reset();
        send(8'h03, 0);
        exp_q.push_back({8'd0, 16'h1357});
        send(8'h13, 0);
        send(8'h57, 0);
        @(posedge clk);
        #1;
        check("midload_count", 32'(word_count), 32'd1);
        check("midload_scoreboard", 32'(exp_q.size()), 32'd0);
        do_reset();
        exp_q.push_back({8'd0, 16'hBEEF});
        send(8'h01, 0);
        send(8'hBE, 0);
        send(8'hEF, 0);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        send(8'h01 ^ 8'hBE ^ 8'hEF, 0);
`endif
        wait_end();
        check("reload_done", 32'(done), 32'd1);
        check("reload_error", 32'(error), 32'd0);
        check("reload_count", 32'(word_count), 32'd1);
        check("reload_scoreboard", 32'(exp_q.size()), 32'd0);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
        // Good and bad checksum on a 1-word load
        for (int k = 0; k < 2; k++) begin
            do_reset();
            exp_q.push_back({8'd0, 16'h1234});
            send(8'h01, 0);
            send(8'h12, 0);
            send(8'h34, 0);
            send((k == 0) ? 8'h27 : 8'h00, 0);
            wait_end();
            check("csum_done", 32'(done), (k == 0) ? 32'd1 : 32'd0);
            check("csum_error", 32'(error), (k == 0) ? 32'd0 : 32'd1);
            check("csum_cpu_reset", 32'(cpu_reset), (k == 0) ? 32'd0 : 32'd1);
        end
`endif

        // Length beyond a 4-word RAM is rejected; exactly 4 is accepted
        for (int k = 0; k < 2; k++) begin
            logic acc;
            do_reset();
            byte_in = (k == 0) ? 8'h05 : 8'h04;
            byte_valid2 = 1'b1;
            acc = 1'b0;
            for (int c = 0; c < 10 && !acc; c++) begin
                @(negedge clk);
                acc = byte_ready2;
                @(posedge clk);
                #1;
            end
            byte_valid2 = 1'b0;
            check("aw2_len_accepted", 32'(acc), 32'd1);
            check("aw2_error", 32'(error2), (k == 0) ? 32'd1 : 32'd0);
            @(posedge clk);
            #1;
            check("aw2_ready_after", 32'(byte_ready2), (k == 0) ? 32'd0 : 32'd1);
            check("aw2_cpu_reset", 32'(cpu_reset2), 32'd1);
            check("aw2_done", 32'(done2), 32'd0);
            check("aw2_no_write", 32'(mw2_seen), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
